// File: rtl/speaker_scheduler_if.sv
// Tone request/response bundle between the sound sources and the speaker scheduler.
// Each multi-bit field packs three requesters, requester i at [i*W +: W].
interface speaker_scheduler_if #(
  parameter int HP_W  = 17,
  parameter int DUR_W = 12
);
  logic [2:0]         req;
  logic [3*HP_W-1:0]  half_period;
  logic [3*DUR_W-1:0] duration_ms;
  logic [2:0]         grant;
  logic [2:0]         done;
  logic               busy;
  logic               speaker;

  modport master (
    output req, half_period, duration_ms,
    input  grant, done, busy, speaker
  );

  modport slave (
    input  req, half_period, duration_ms,
    output grant, done, busy, speaker
  );
endinterface

// File: rtl/speaker_scheduler.sv
// Fixed-priority arbiter sharing one speaker pin between three tone requesters,
// with a square-wave generator, millisecond duration timing and an inter-tone gap.
module speaker_scheduler #(
  parameter int CLK_HZ      = 25000000,
  parameter int TICK_CYCLES = 25000,
  parameter int GAP_CYCLES  = 250000,
  parameter int HP_W        = 17,
  parameter int DUR_W       = 12
) (
  input logic                clk,
  input logic                reset,
  speaker_scheduler_if.slave sched_io
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  if (GAP_CYCLES < 1 || TICK_CYCLES < 1 || CLK_HZ < 1) begin : g_param_check
    $error("speaker_scheduler: CLK_HZ, TICK_CYCLES and GAP_CYCLES must all be >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       done_q, done_d;
  logic [2:0]       mask_q, mask_d;
  logic             speaker_q, speaker_d;
  logic             timed_q, timed_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [HP_W-1:0]  tone_q, tone_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] ticks_q, ticks_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [2:0]       elig;
  logic [2:0]       pickOh;
  logic [2:0]       maskSet;
  logic [HP_W-1:0]  hSel, hEff;
  logic [DUR_W-1:0] dSel;
  logic             completion;
  logic             toGap;

  // Lowest set bit of the eligible vector is the winning requester.
  always_comb begin
    elig   = sched_io.req & ~mask_q;
    pickOh = elig & (~elig + 3'd1);
    hSel   = sched_io.half_period[0 +: HP_W];
    dSel   = sched_io.duration_ms[0 +: DUR_W];
    if (pickOh[1]) begin
      hSel = sched_io.half_period[HP_W +: HP_W];
      dSel = sched_io.duration_ms[DUR_W +: DUR_W];
    end else if (pickOh[2]) begin
      hSel = sched_io.half_period[2*HP_W +: HP_W];
      dSel = sched_io.duration_ms[2*DUR_W +: DUR_W];
    end
    hEff = (hSel == '0) ? HP_W'(1) : hSel;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = 3'b000;
    speaker_d  = speaker_q;
    timed_d    = timed_q;
    hp_d       = hp_q;
    tone_d     = tone_q;
    pre_d      = pre_q;
    ticks_d    = ticks_q;
    gap_d      = gap_q;
    maskSet    = 3'b000;
    completion = 1'b0;
    toGap      = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig != 3'b000) begin
          state_d   = PLAY;
          grant_d   = pickOh;
          hp_d      = hEff;
          tone_d    = hEff - 1'b1;
          pre_d     = PRE_MAX;
          ticks_d   = dSel;
          timed_d   = (dSel != '0);
          speaker_d = 1'b0;
        end
      end

      PLAY: begin
        if (tone_q == '0) begin
          tone_d    = hp_q - 1'b1;
          speaker_d = ~speaker_q;
        end else begin
          tone_d = tone_q - 1'b1;
        end

        if (pre_q == '0) begin
          pre_d = PRE_MAX;
          if (ticks_q != '0) ticks_d = ticks_q - 1'b1;
        end else begin
          pre_d = pre_q - 1'b1;
        end

        // Completion outranks a dropped request and a higher-priority arrival.
        completion = timed_q && (pre_q == '0) && (ticks_q == DUR_W'(1));
        if (completion) begin
          done_d  = grant_q;
          maskSet = grant_q;
          toGap   = 1'b1;
        end else if ((sched_io.req & grant_q) == 3'b000) begin
          toGap = 1'b1;
        end else if ((elig & (grant_q - 3'd1)) != 3'b000) begin
          toGap = 1'b1;
        end

        if (toGap) begin
          state_d   = GAP;
          grant_d   = 3'b000;
          speaker_d = 1'b0;
          gap_d     = GAP_MAX;
        end
      end

      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end

      default: state_d = IDLE;
    endcase

    mask_d = (mask_q | maskSet) & sched_io.req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      done_q    <= 3'b000;
      mask_q    <= 3'b000;
      speaker_q <= 1'b0;
      timed_q   <= 1'b0;
      hp_q      <= '0;
      tone_q    <= '0;
      pre_q     <= '0;
      ticks_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      mask_q    <= mask_d;
      speaker_q <= speaker_d;
      timed_q   <= timed_d;
      hp_q      <= hp_d;
      tone_q    <= tone_d;
      pre_q     <= pre_d;
      ticks_q   <= ticks_d;
      gap_q     <= gap_d;
    end
  end

  assign sched_io.grant   = grant_q;
  assign sched_io.done    = done_q;
  assign sched_io.busy    = (state_q != IDLE);
  assign sched_io.speaker = speaker_q;

endmodule

// File: tb/tb_speaker_scheduler.sv
// Directed bench for speaker_scheduler: expected tones are queued as stimulus is applied
// and a negedge monitor measures each observed tone and its gap against the queue head.
module tb_speaker_scheduler;
  localparam int HP_W  = 17;
  localparam int DUR_W = 12;
  localparam int TICK  = 10;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic reset;

  speaker_scheduler_if #(.HP_W(HP_W), .DUR_W(DUR_W)) sched ();

  speaker_scheduler #(
    .CLK_HZ(25000000),
    .TICK_CYCLES(TICK),
    .GAP_CYCLES(GAP),
    .HP_W(HP_W),
    .DUR_W(DUR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sched_io(sched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] grant;
    int         playLen;
    logic [2:0] done;
    int         gapLen;
  } toneExp_t;

  toneExp_t expQ[$];
  int nAsserts = 0;
  int nFails   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] reqVal);
    sched.req = reqVal;
  endtask

  task automatic configTone(input int idx, input int h, input int d);
    sched.half_period[idx*HP_W +: HP_W]   = HP_W'(h);
    sched.duration_ms[idx*DUR_W +: DUR_W] = DUR_W'(d);
  endtask

  task automatic expectTone(input logic [2:0] g, input int len, input logic [2:0] d, input int gl);
    toneExp_t e;
    e.grant   = g;
    e.playLen = len;
    e.done    = d;
    e.gapLen  = gl;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor state: one tone is its grant window plus the busy-but-silent window after it.
  logic       inTone = 1'b0;
  logic       inGap  = 1'b0;
  logic [2:0] curGrant;
  logic [2:0] doneAtGap;
  int         playCnt, gapCnt, strayDone;

  task automatic finishTone();
    toneExp_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_tone_grant", 32'(curGrant), 32'h0);
    end else begin
      e = expQ.pop_front();
      checkOutput("tone_grant", 32'(curGrant), 32'(e.grant));
      checkOutput("tone_play_len", 32'(playCnt), 32'(e.playLen));
      checkOutput("tone_done", 32'(doneAtGap), 32'(e.done));
      checkOutput("tone_gap_len", 32'(gapCnt), 32'(e.gapLen));
      checkOutput("tone_stray_done", 32'(strayDone), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (inGap) begin
      if (sched.busy && sched.grant == 3'b000) begin
        gapCnt++;
        if (sched.done != 3'b000) strayDone++;
      end else begin
        inGap = 1'b0;
        finishTone();
      end
    end else if (inTone) begin
      if (sched.grant == curGrant) begin
        playCnt++;
        if (sched.done != 3'b000) strayDone++;
      end else begin
        inTone    = 1'b0;
        doneAtGap = sched.done;
        gapCnt    = sched.busy ? 1 : 0;
        if (sched.busy) inGap = 1'b1;
        else            finishTone();
      end
    end
    if (!inTone && !inGap && sched.grant != 3'b000) begin
      inTone    = 1'b1;
      curGrant  = sched.grant;
      playCnt   = 1;
      strayDone = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset = 1'b1;
    sched.req         = 3'b000;
    sched.half_period = '0;
    sched.duration_ms = '0;
    waitCycles(2);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_grant", 32'(sched.grant), 32'h0);
    checkOutput("reset_done", 32'(sched.done), 32'h0);
    checkOutput("reset_busy", 32'(sched.busy), 32'h0);
    checkOutput("reset_speaker", 32'(sched.speaker), 32'h0);

    $display("[TB] single timed tone h=3 D=2");
    configTone(2, 3, 2);
    waitCycles(1);
    applyStimulus(3'b100);
    expectTone(3'b100, 20, 3'b100, 4);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput($sformatf("s1_speaker_c%0d", k), 32'(sched.speaker), 32'((k / 3) % 2));
      if (k == 0) begin
        checkOutput("s1_grant_latency", 32'(sched.grant), 32'h4);
        checkOutput("s1_busy_latency", 32'(sched.busy), 32'h1);
      end
    end
    waitCycles(6);
    @(negedge clk);
    checkOutput("s1_masked_idle", 32'({sched.busy, sched.grant}), 32'h0);
    applyStimulus(3'b000);
    waitCycles(2);

    $display("[TB] priority between requesters 1 and 2");
    configTone(1, 2, 1);
    configTone(2, 2, 1);
    applyStimulus(3'b110);
    expectTone(3'b010, 10, 3'b010, 4);
    expectTone(3'b100, 10, 3'b100, 4);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s2_priority_grant", 32'(sched.grant), 32'h2);
    waitCycles(40);
    applyStimulus(3'b000);
    waitCycles(3);

    $display("[TB] preemption of a continuous tone");
    configTone(2, 3, 0);
    configTone(0, 1, 1);
    applyStimulus(3'b100);
    expectTone(3'b100, 8, 3'b000, 4);
    waitCycles(8);
    applyStimulus(3'b101);
    expectTone(3'b001, 10, 3'b001, 4);
    expectTone(3'b100, 6, 3'b000, 4);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s3_preempt_grant_drop", 32'(sched.grant), 32'h0);
    checkOutput("s3_preempt_speaker", 32'(sched.speaker), 32'h0);
    checkOutput("s3_preempt_no_done", 32'(sched.done), 32'h0);
    waitCycles(5);
    @(negedge clk);
    checkOutput("s3_regrant_req0", 32'(sched.grant), 32'h1);
    waitCycles(20);
    applyStimulus(3'b001);
    waitCycles(8);
    applyStimulus(3'b000);
    waitCycles(3);

    $display("[TB] one-shot mask on a held timed request");
    configTone(1, 2, 1);
    applyStimulus(3'b010);
    expectTone(3'b010, 10, 3'b010, 4);
    waitCycles(20);
    @(negedge clk);
    checkOutput("s4_no_regrant", 32'(sched.grant), 32'h0);
    waitCycles(1);
    applyStimulus(3'b000);
    waitCycles(1);
    applyStimulus(3'b010);
    expectTone(3'b010, 10, 3'b010, 4);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s4_regrant", 32'(sched.grant), 32'h2);
    waitCycles(20);
    applyStimulus(3'b000);
    waitCycles(3);

    $display("[TB] h=0 and half_period latched at grant");
    configTone(2, 0, 1);
    applyStimulus(3'b100);
    expectTone(3'b100, 10, 3'b100, 4);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("s5_speaker_c%0d", k), 32'(sched.speaker), 32'(k % 2));
      if (k == 5) sched.half_period[2*HP_W +: HP_W] = HP_W'(5);
    end
    waitCycles(8);
    applyStimulus(3'b000);
    waitCycles(3);

    $display("[TB] completion coincident with higher-priority request");
    configTone(2, 2, 1);
    configTone(0, 1, 1);
    applyStimulus(3'b100);
    expectTone(3'b100, 10, 3'b100, 4);
    waitCycles(10);
    applyStimulus(3'b101);
    expectTone(3'b001, 10, 3'b001, 4);
    waitCycles(25);
    applyStimulus(3'b000);
    waitCycles(3);

    $display("[TB] completion coincident with request drop");
    configTone(0, 2, 1);
    applyStimulus(3'b001);
    expectTone(3'b001, 10, 3'b001, 4);
    waitCycles(10);
    applyStimulus(3'b000);
    waitCycles(8);

    $display("[TB] reset in the middle of a tone");
    configTone(1, 3, 2);
    applyStimulus(3'b010);
    expectTone(3'b010, 6, 3'b000, 0);
    waitCycles(6);
    @(negedge clk);
    checkOutput("s6_speaker_before_reset", 32'(sched.speaker), 32'h1);
    reset = 1'b1;
    applyStimulus(3'b000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s6_reset_speaker", 32'(sched.speaker), 32'h0);
    checkOutput("s6_reset_grant", 32'(sched.grant), 32'h0);
    checkOutput("s6_reset_busy", 32'(sched.busy), 32'h0);
    checkOutput("s6_reset_done", 32'(sched.done), 32'h0);
    waitCycles(1);
    reset = 1'b0;
    waitCycles(5);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule

// File: doc/speaker_scheduler.md
# speaker_scheduler

Shares the board's single `speaker` pin between three tone requesters: siren, alert beep and UI click. It arbitrates by fixed priority, generates the granted requester's square wave, and times its duration in millisecond ticks. Between tones it inserts a silent gap. It sits between the sound sources and the speaker output, and it replaces free-running per-source dividers driving the pin directly.

## Interface
- `CLK_HZ`, 25000000: clock frequency. Documentation only; the design relies on `TICK_CYCLES`.
- `TICK_CYCLES`, 25000: clock cycles per duration tick (1 ms at 25 MHz).
- `GAP_CYCLES`, 250000: silent cycles after every tone end (10 ms). Must be ≥1.
- `HP_W`, 17: width of each half-period field.
- `DUR_W`, 12: width of each duration field.
- `clk`  in  1  system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  level requests; bit 0 has highest priority.
- `half_period`  in  3*HP_W  per-requester half-wave length in cycles; field i is bits [i*HP_W +: HP_W].
- `duration_ms`  in  3*DUR_W  per-requester length in ticks; 0 means continuous while `req` is held.
- `grant`  out  3  one-hot grant for the requester currently playing.
- `done`  out  3  one-cycle pulse when a timed tone completes.
- `busy`  out  1  high in PLAY or GAP.
- `speaker`  out  1  square-wave output.

## Operation
- The state machine has three states: IDLE, PLAY, GAP. Reset puts it in IDLE.
- Reset values: `speaker`=0, `grant`=0, `done`=0, `busy`=0, all counters 0, all masks cleared.
- Eligibility: requester i is eligible when `req[i]`=1 and `mask[i]`=0.
- IDLE: if any requester is eligible, select the lowest eligible index i and go to PLAY.
  - On entry, latch `half_period[i]` as h and `duration_ms[i]` as D.
  - A latched h=0 is treated as h=1.
  - Load the tone counter with h-1, the tick prescaler with TICK_CYCLES-1, and the tick count with D.
- PLAY:
  - `grant[i]`=1.
  - The tone counter decrements each cycle. When it reaches 0, `speaker` toggles and the counter reloads h-1.
  - The prescaler decrements each cycle. When it reaches 0, it reloads and the tick count decrements.
  - Changes to `half_period` or `duration_ms` during PLAY are ignored.
- PLAY exits, highest precedence first:
  1. Completion: D≠0 and the tick count reaches 0. Pulse `done[i]`, set `mask[i]`, go to GAP.
  2. Abort: `req[i]` drops. Go to GAP with no `done`.
  3. Preemption: any eligible j<i. Go to GAP with no `done`. Requester i is not masked and competes again after the gap.
- GAP:
  - `grant`=0, `speaker`=0, `busy`=1.
  - Count GAP_CYCLES cycles, then go to IDLE.
- Masks: `mask[i]` clears on any cycle where `req[i]`=0. A timed requester must therefore drop and re-raise `req` to play again. Continuous tones (D=0) never set a mask.
- Widths:
  - The tick count is DUR_W bits.
  - The tone counter is HP_W bits.
  - The prescaler is ceil(log2(TICK_CYCLES)) bits.
  - No counter wraps; all reloads are explicit.

## Timing
- Grant latency: `req` is sampled in IDLE at edge n; `grant` and `busy` are high from cycle n+1. Call that first PLAY cycle cycle 0.
- Tone edges: `speaker` is 0 in cycle 0, rises at cycle h, falls at 2h, and so on. Period is 2h cycles.
- Timed tone (D≠0): the last PLAY cycle is cycle D*TICK_CYCLES-1. `done[i]` is high for exactly one cycle, the first GAP cycle, when `grant` is already 0.
- Abort or preemption: `grant` and `speaker` go to 0 the cycle after the condition is sampled.
- Gap: the first IDLE cycle is exactly GAP_CYCLES cycles after GAP entry. The earliest next `grant` is one cycle later.
- Simultaneous events:
  - Completion and `req` drop in the same cycle: completion wins and `done` pulses.
  - Completion and a higher-priority request in the same cycle: completion wins.
- `reset` mid-PLAY or mid-GAP: all outputs return to reset values on the next edge. No `done` is emitted.

## Test plan
Parameters for every scenario: TICK_CYCLES=10, GAP_CYCLES=4.
- Single timed tone: `req`=3'b100, h=3, D=2 → `grant`=3'b100 for 20 cycles; `speaker` toggles every 3 cycles; `done[2]` pulses once; `busy` stays high 4 more cycles, then IDLE.
- Priority: `req`=3'b110 asserted together → `grant`=3'b010. After requester 1 completes and the gap ends, `grant`=3'b100.
- Preemption: requester 2 playing continuous (D=0); at cycle 7 `req[0]` rises → `grant[2]` drops next cycle, no `done[2]`. After the 4-cycle gap, `grant`=3'b001.
- One-shot mask: requester 1 timed, D=1, `req[1]` held after `done` → no regrant. Drop `req[1]` for 1 cycle and re-raise → grant after IDLE.
- h=0 and field latch: h=0 → `speaker` toggles every cycle. Changing `half_period` mid-PLAY → no change in toggle rate.
- Reset mid-tone and simultaneous exit:
  - `reset` at cycle 5 of PLAY → next cycle `speaker`=0, `grant`=0, `busy`=0, no `done`.
  - Completion coincident with `req` drop → `done` still pulses.
